// File: rtl/pix_pack_16to32_pkg.sv
// Shared types and helpers for the 16-to-32 pixel packer.
// Pack FSM states, default widths and the word/pixel width relationship check.
package pix_pack_16to32_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        LO      = 2'd1,
        HI      = 2'd2
    } pack_state_t;

    localparam int PIX_W_DEF  = 16;
    localparam int WORD_W_DEF = 2 * PIX_W_DEF;
    localparam int CNT_W_DEF  = 20;

    function automatic bit widths_ok(input int pix_w, input int word_w);
        return word_w == 2 * pix_w;
    endfunction

endpackage

// File: rtl/pix_pack_16to32_q2.sv
// Two-entry FIFO-order output queue; head is registered, so a push shows at the head next cycle.
// A push is taken when the queue is not full or when it pops in the same cycle; otherwise it is ignored.
module pix_pack_16to32_q2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (do_push) begin
                        slot0 <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (do_push && do_pop) begin
                        slot0 <= push_data;
                    end else if (do_push) begin
                        slot1 <= push_data;
                        count <= 2'd2;
                    end else if (do_pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Popping shifts the tail forward; a simultaneous push refills the tail.
                    if (do_pop) begin
                        slot0 <= slot1;
                        if (do_push) slot1 <= push_data;
                        else         count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = slot0;

endmodule

// File: rtl/pix_pack_16to32.sv
// Packs framed 16-bit pixels into 32-bit FIFO words (odd lines padded); 1-cycle push-to-wr_en latency.
// A 2-entry queue absorbs fifo_wr_vld stalls; a word arriving while full and not draining is dropped (sticky ovf_err).
module pix_pack_16to32
    import pix_pack_16to32_pkg::*;
#(
    parameter int               PIX_W   = PIX_W_DEF,
    parameter int               WORD_W  = WORD_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [PIX_W-1:0] PAD_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_vs,
    input  logic              pix_de,
    input  logic              pix_eol,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              fifo_wr_en,
    input  logic              fifo_wr_vld,
    output logic [WORD_W-1:0] fifo_wr_data,
    output logic [CNT_W-1:0]  frame_words,
    output logic              frame_done,
    output logic              ovf_err,
    input  logic              err_clr
);

    if (!widths_ok(PIX_W, WORD_W)) begin : g_width_check
        $error("pix_pack_16to32: WORD_W must equal 2*PIX_W");
    end

    pack_state_t       state;
    pack_state_t       eff_state;
    logic [PIX_W-1:0]  low_half;
    logic [CNT_W-1:0]  word_cnt;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              q_full;
    logic              q_empty;
    logic              pop;
    logic              accept;
    logic              drop;

    // A frame start discards any held half, so a same-cycle pixel is seen from LO.
    always_comb begin
        eff_state = pix_vs ? LO : state;
        push      = 1'b0;
        push_data = '0;
        if (pix_de) begin
            case (eff_state)
                LO: begin
                    if (pix_eol) begin
                        push      = 1'b1;
                        push_data = {PAD_VAL, pix_data};
                    end
                end
                HI: begin
                    push      = 1'b1;
                    push_data = {pix_data, low_half};
                end
                default: ;
            endcase
        end
    end

    assign pop    = !q_empty && fifo_wr_vld;
    assign accept = push && (!q_full || pop);
    assign drop   = push && q_full && !pop;

    pix_pack_16to32_q2 #(.W(WORD_W)) u_q2 (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (fifo_wr_data)
    );

    assign fifo_wr_en = !q_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_VS;
            low_half    <= '0;
            word_cnt    <= '0;
            frame_words <= '0;
            frame_done  <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            state <= eff_state;
            if (pix_de) begin
                if (eff_state == LO && !pix_eol) begin
                    low_half <= pix_data;
                    state    <= HI;
                end else if (eff_state == HI) begin
                    state <= LO;
                end
            end

            // The first frame start after reset has no previous frame to report.
            if (pix_vs) begin
                if (state != WAIT_VS) begin
                    frame_done  <= 1'b1;
                    frame_words <= word_cnt;
                end
                word_cnt <= {{(CNT_W-1){1'b0}}, accept};
            end else if (accept && (word_cnt != {CNT_W{1'b1}})) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (drop)         ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
        end
    end

endmodule
